regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (rd / regwrite / rd_data) between NUM_REQ writeback requesters, e.g. ALU, load unit and multi-cycle mul/div.
- Uses round-robin arbitration with a valid/ready handshake and a registered output stage.
- Keeps a 32-entry pending-write scoreboard so issue logic can stall on RAW hazards against in-flight producers.
- Sits between the execution units and register_file; its outputs drive the register_file write port directly.

---
 rtl/regfile_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port, with a pending-write
// scoreboard for RAW stalls. Define RF_FWD_EN to add a bypass from the registered output stage.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [5*NUM_REQ-1:0]    req_rd_i,
  input  logic [XLEN*NUM_REQ-1:0] req_data_i,
  input  logic                    alloc_valid_i,
  input  logic [4:0]              alloc_rd_i,
  input  logic [4:0]              rs1_i,
  input  logic [4:0]              rs2_i,
  output logic                    rs1_busy_o,
  output logic                    rs2_busy_o,
  output logic [4:0]              rf_rd_o,
  output logic                    rf_regwrite_o,
  output logic [XLEN-1:0]         rf_rd_data_o
`ifdef RF_FWD_EN
  ,
  output logic [XLEN-1:0]         rs1_fwd_data_o,
  output logic [XLEN-1:0]         rs2_fwd_data_o
`endif
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] grant_idx, cand;
  logic            grant_vld;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  logic [4:0]      rf_rd_q;
  logic            rf_regwrite_q;
  logic [XLEN-1:0] rf_rd_data_q;
  logic [31:0]     sb_q, sb_d;

  // Search from the pointer, wrapping modulo NUM_REQ; first valid requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PtrW'((32'(ptr_q) + k) % NUM_REQ);
      if (!grant_vld && req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (reset_i) begin
      grant_vld = 1'b0;
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grant_vld) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == PtrW'(k)) begin
        sel_rd   = req_rd_i[5*k +: 5];
        sel_data = req_data_i[XLEN*k +: XLEN];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (grant_idx == PtrW'(NUM_REQ - 1)) ? '0 : grant_idx + PtrW'(1);
    end
  end

  // Clear on the commit edge first so a same-edge alloc of that register wins.
  always_comb begin
    sb_d = sb_q;
    if (rf_regwrite_q) begin
      sb_d[rf_rd_q] = 1'b0;
    end
    if (alloc_valid_i && (alloc_rd_i != 5'd0)) begin
      sb_d[alloc_rd_i] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q         <= '0;
      sb_q          <= '0;
      rf_rd_q       <= '0;
      rf_regwrite_q <= 1'b0;
      rf_rd_data_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      sb_q  <= sb_d;
      if (grant_vld) begin
        rf_rd_q       <= sel_rd;
        rf_rd_data_q  <= sel_data;
        rf_regwrite_q <= (sel_rd != 5'd0);
      end else begin
        rf_regwrite_q <= 1'b0;
      end
    end
  end

  assign rf_rd_o       = rf_rd_q;
  assign rf_regwrite_o = rf_regwrite_q;
  assign rf_rd_data_o  = rf_rd_data_q;

`ifdef RF_FWD_EN
  logic fwd1, fwd2;
  assign fwd1           = rf_regwrite_q && (rf_rd_q == rs1_i) && (rs1_i != 5'd0);
  assign fwd2           = rf_regwrite_q && (rf_rd_q == rs2_i) && (rs2_i != 5'd0);
  assign rs1_busy_o     = sb_q[rs1_i] && (rs1_i != 5'd0) && !fwd1;
  assign rs2_busy_o     = sb_q[rs2_i] && (rs2_i != 5'd0) && !fwd2;
  assign rs1_fwd_data_o = fwd1 ? rf_rd_data_q : '0;
  assign rs2_fwd_data_o = fwd2 ? rf_rd_data_q : '0;
`else
  assign rs1_busy_o = sb_q[rs1_i] && (rs1_i != 5'd0);
  assign rs2_busy_o = sb_q[rs2_i] && (rs2_i != 5'd0);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a per-cycle reference model plus literal spot checks.
module tb_regfile_wb_arbiter;
  localparam int N = 2;
  localparam int X = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [5*N-1:0]  req_rd;
  logic [X*N-1:0]  req_data;
  logic            alloc_valid;
  logic [4:0]      alloc_rd, rs1, rs2;
  logic            rs1_busy, rs2_busy;
  logic [4:0]      rf_rd;
  logic            rf_regwrite;
  logic [X-1:0]    rf_rd_data;
`ifdef RF_FWD_EN
  logic [X-1:0]    rs1_fwd_data, rs2_fwd_data;
`endif

  regfile_wb_arbiter #(.NUM_REQ(N), .XLEN(X)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_rd_i      (req_rd),
    .req_data_i    (req_data),
    .alloc_valid_i (alloc_valid),
    .alloc_rd_i    (alloc_rd),
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .rs1_busy_o    (rs1_busy),
    .rs2_busy_o    (rs2_busy),
    .rf_rd_o       (rf_rd),
    .rf_regwrite_o (rf_regwrite),
    .rf_rd_data_o  (rf_rd_data)
`ifdef RF_FWD_EN
    ,
    .rs1_fwd_data_o(rs1_fwd_data),
    .rs2_fwd_data_o(rs2_fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the architectural view (pointer, pending set, pending RF write).
  int        m_ptr = 0, n_ptr = 0;
  bit [31:0] m_pend = '0, n_pend = '0;
  bit        m_wr = 1'b0, n_wr = 1'b0;
  bit [4:0]  m_rd = '0, n_rd = '0;
  bit [31:0] m_data = '0, n_data = '0;

  function automatic bit exp_busy(input bit [4:0] r);
    bit b;
    b = (r != 0) && m_pend[r];
`ifdef RF_FWD_EN
    if (m_wr && m_rd == r) b = 1'b0;
`endif
    return b;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      int g;
      logic [N-1:0] exp_ready;
      g = -1;
      exp_ready = '0;
      if (!reset) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      check("m_ready", req_ready, exp_ready);
      check("m_regwrite", rf_regwrite, m_wr);
      if (m_wr) begin
        check("m_rd", rf_rd, m_rd);
        check("m_data", rf_rd_data, m_data);
      end
      check("m_busy1", rs1_busy, exp_busy(rs1));
      check("m_busy2", rs2_busy, exp_busy(rs2));
`ifdef RF_FWD_EN
      check("m_fwd1", rs1_fwd_data, (m_wr && m_rd == rs1 && rs1 != 0) ? m_data : 0);
      check("m_fwd2", rs2_fwd_data, (m_wr && m_rd == rs2 && rs2 != 0) ? m_data : 0);
`endif
      if (reset) begin
        n_ptr = 0; n_pend = '0; n_wr = 0; n_rd = '0; n_data = '0;
      end else begin
        n_pend = m_pend;
        if (m_wr) n_pend[m_rd] = 1'b0;
        if (alloc_valid && alloc_rd != 0) n_pend[alloc_rd] = 1'b1;
        n_ptr = m_ptr; n_wr = 1'b0; n_rd = m_rd; n_data = m_data;
        if (g >= 0) begin
          n_ptr  = (g + 1) % N;
          n_rd   = req_rd[5*g +: 5];
          n_data = req_data[X*g +: X];
          n_wr   = (n_rd != 0);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (chk_en) begin
      m_ptr <= n_ptr; m_pend <= n_pend; m_wr <= n_wr; m_rd <= n_rd; m_data <= n_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] d);
    req_rd[5*i +: 5] = rd;
    req_data[X*i +: X] = d;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
    alloc_valid = 1'b0; alloc_rd = '0; rs1 = 5'd5; rs2 = 5'd9;
    @(posedge clk); #1; chk_en = 1'b1;
    cyc(); reset = 1'b0;
    @(negedge clk);
    check("rst_regwrite", rf_regwrite, 0);
    check("rst_rd", rf_rd, 0);
    check("rst_data", rf_rd_data, 0);
    check("rst_busy", rs1_busy, 0);

    // Single write to x5
    cyc(); alloc_valid = 1'b1; alloc_rd = 5'd5;
    @(negedge clk); check("sw_busy_pre", rs1_busy, 0);
    cyc(); alloc_valid = 1'b0; req_valid = 2'b01; set_req(0, 5'd5, 32'hDEADBEEF);
    @(negedge clk); check("sw_ready", req_ready, 2'b01); check("sw_busy", rs1_busy, 1);
    cyc(); req_valid = '0;
    @(negedge clk);
    check("sw_regwrite", rf_regwrite, 1);
    check("sw_rd", rf_rd, 5);
    check("sw_data", rf_rd_data, 32'hDEADBEEF);
`ifdef RF_FWD_EN
    check("sw_busy_out", rs1_busy, 0);
`else
    check("sw_busy_out", rs1_busy, 1);
`endif
    cyc();
    @(negedge clk); check("sw_regwrite_off", rf_regwrite, 0); check("sw_busy_post", rs1_busy, 0);

    // Output stage writing x9 while rs2 queries it
    cyc(); alloc_valid = 1'b1; alloc_rd = 5'd9;
    cyc(); alloc_valid = 1'b0; req_valid = 2'b01; set_req(0, 5'd9, 32'hA5A5A5A5);
    @(negedge clk); check("fw_ready", req_ready, 2'b01);
    cyc(); req_valid = '0;
    @(negedge clk);
`ifdef RF_FWD_EN
    check("fw_busy", rs2_busy, 0);
    check("fw_data", rs2_fwd_data, 32'hA5A5A5A5);
`else
    check("fw_busy", rs2_busy, 1);
`endif

    // Contention after a fresh reset: grants 0,1,0,1
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0; alloc_valid = 1'b1; alloc_rd = 5'd1;
    cyc(); alloc_rd = 5'd2;
    cyc(); alloc_valid = 1'b0; req_valid = 2'b11;
    set_req(0, 5'd1, 32'h11111111); set_req(1, 5'd2, 32'h22222222);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ct_ready", req_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
      if (i > 0) check("ct_regwrite", rf_regwrite, 1);
      cyc();
      if (i == 3) req_valid = '0;
    end
    @(negedge clk); check("ct_regwrite_last", rf_regwrite, 1); check("ct_rd_last", rf_rd, 2);
    cyc();
    @(negedge clk); check("ct_regwrite_off", rf_regwrite, 0);

    // x0 write and x0 alloc
    cyc(); req_valid = 2'b10; set_req(1, 5'd0, 32'h00001234);
    alloc_valid = 1'b1; alloc_rd = 5'd0; rs1 = 5'd0;
    @(negedge clk); check("x0_ready", req_ready, 2'b10);
    cyc(); req_valid = '0; alloc_valid = 1'b0;
    @(negedge clk); check("x0_regwrite", rf_regwrite, 0); check("x0_busy", rs1_busy, 0);

    // Set/clear collision on x7
    cyc(); alloc_valid = 1'b1; alloc_rd = 5'd7; rs1 = 5'd7;
    cyc(); alloc_valid = 1'b0; req_valid = 2'b01; set_req(0, 5'd7, 32'h77);
    @(negedge clk); check("col_ready", req_ready, 2'b01);
    cyc(); req_valid = '0; alloc_valid = 1'b1; alloc_rd = 5'd7;
    @(negedge clk); check("col_regwrite", rf_regwrite, 1); check("col_rd", rf_rd, 7);
    cyc(); alloc_valid = 1'b0;
    @(negedge clk); check("col_busy", rs1_busy, 1);
    cyc(); req_valid = 2'b01;
    cyc(); req_valid = '0;
    cyc();
    @(negedge clk); check("col_busy_clr", rs1_busy, 0);

    // Reset mid-flight; pointer left at 1 beforehand
    cyc(); alloc_valid = 1'b1; alloc_rd = 5'd3; rs1 = 5'd3;
    cyc(); alloc_valid = 1'b0; req_valid = 2'b01; set_req(0, 5'd3, 32'h33);
    @(negedge clk); check("rm_ready", req_ready, 2'b01);
    cyc(); reset = 1'b1; req_valid = 2'b11; set_req(1, 5'd4, 32'h44);
    @(negedge clk); check("rm_ready_rst", req_ready, 2'b00);
    cyc(); reset = 1'b0;
    @(negedge clk);
    check("rm_regwrite", rf_regwrite, 0);
    check("rm_busy", rs1_busy, 0);
    check("rm_grant0", req_ready, 2'b01);
    cyc(); req_valid = '0;
    cyc(); cyc();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
